fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core; sits directly upstream of decode/control.
- Owns the PC; fetches from a single-ported instruction memory with a ready handshake.
- Applies branch, jump and jr redirects from decode; honours hazard-unit stall/flush.
- Presents Instr_D and PCPlus4_D, whose Instr_D[31:26]/[5:0] drive the control decoder's Op/Funct.

---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, imem handshake, redirects and IF/ID register.
// Optional IF_PERF_CNT_EN adds FetchCount/StallCount performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] IMemAddr,
  output logic        IMemReq,
  input  logic        IMemReady,
  input  logic [31:0] IMemRdata,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  input  logic        JumpD,
  input  logic [31:0] JumpTargetD,
  input  logic        JrD,
  input  logic [31:0] JrTargetD,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        ValidD,
  output logic        Halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pc_plus4, redir_tgt;
  logic active, redir, is_halt, accept, load;
  // next-state, next-PC and handshake outputs
  always_comb begin
    pc_plus4  = pc + 32'd4;
    active    = (state == FETCH) || (state == WAIT);
    redir     = JrD || BranchTakenD || JumpD;
    redir_tgt = (JrD ? JrTargetD : BranchTakenD ? BranchTargetD : JumpTargetD) & 32'hFFFF_FFFC;
    is_halt   = active && IMemReady && (IMemRdata == HALT_INSTR);
    accept    = active && IMemReady && !StallF && !is_halt;
    load      = accept && !FlushD;
    pc_nx     = accept ? (redir ? redir_tgt : pc_plus4)
              : (active && !IMemReady && !StallF && redir) ? redir_tgt : pc;
    state_nx  = (state == IDLE) ? FETCH
              : (state == HALT || is_halt) ? HALT
              : IMemReady ? FETCH : WAIT;
    IMemReq   = active;
    IMemAddr  = pc;
    Halted    = (state == HALT);
  end
  // state and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end
  // IF/ID pipeline register: stall holds, otherwise load instruction or bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Instr_D   <= '0;
      PCPlus4_D <= '0;
      ValidD    <= 1'b0;
    end else if (!StallD) begin
      Instr_D   <= load ? IMemRdata : '0;
      PCPlus4_D <= load ? pc_plus4 : '0;
      ValidD    <= load;
    end
  end
`ifdef IF_PERF_CNT_EN
  // accepted-instruction and fetch-stall counters; idle in HALT since not active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (load && !StallD) FetchCount <= FetchCount + 32'd1;
      if (active && (StallF || !IMemReady)) StallCount <= StallCount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven, directed and randomized model-checked bench for fetch_stage.
module tb_fetch_stage;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, branch_target, jump_target, jr_target, instr_d, pcplus4_d;
  logic imem_req, imem_ready, stall_f, stall_d, flush_d, branch_taken, jump, jr, valid_d, halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif
  logic [31:0] mem [64];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr[7:2]];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .IMemAddr(imem_addr), .IMemReq(imem_req), .IMemReady(imem_ready),
    .IMemRdata(imem_rdata), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
    .BranchTakenD(branch_taken), .BranchTargetD(branch_target), .JumpD(jump),
    .JumpTargetD(jump_target), .JrD(jr), .JrTargetD(jr_target), .Instr_D(instr_d),
    .PCPlus4_D(pcplus4_d), .ValidD(valid_d), .Halted(halted)
`ifdef IF_PERF_CNT_EN
    , .FetchCount(fetch_count), .StallCount(stall_count)
`endif
  );

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] t1, t2, addr, instr, pcp4;
    logic        valid;
  } vec_t;
  vec_t tbl [18];

  function automatic vec_t v(logic [6:0] ctl, logic [31:0] t1, t2, addr, instr, pcp4, logic valid);
    v.ctl = ctl; v.t1 = t1; v.t2 = t2; v.addr = addr; v.instr = instr; v.pcp4 = pcp4; v.valid = valid;
  endfunction

  function automatic logic [31:0] w(logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ctl = {ready, stallF, stallD, flushD, branch, jump, jr}
  task automatic drv(logic [6:0] ctl, logic [31:0] bt, jt, rt);
    {imem_ready, stall_f, stall_d, flush_d, branch_taken, jump, jr} = ctl;
    branch_target = bt; jump_target = jt; jr_target = rt;
  endtask

  // behavioural model
  logic [31:0] m_pc, m_instr, m_pcp4, m_fc, m_sc;
  logic m_run, m_halt, m_valid;

  task automatic m_reset();
    m_pc = 32'h0; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_run = 0; m_halt = 0; m_fc = 0; m_sc = 0;
  endtask

  task automatic step(string name, logic [6:0] ctl, logic [31:0] bt, jt, rt);
    logic rdy, sf, sd, fd, br, jp, j, live, take, rd;
    logic [31:0] word, old_pc, tgt;
    drv(ctl, bt, jt, rt);
    {rdy, sf, sd, fd, br, jp, j} = ctl;
    word = mem[m_pc[7:2]];
    old_pc = m_pc;
    live = m_run && !m_halt;
    take = live && rdy && !sf && word != HALT_W;
    rd = br || jp || j;
    tgt = (j ? rt : br ? bt : jt);
    tgt[1:0] = 2'b00;
    if (live && !sf && (take || (!rdy && rd))) m_pc = rd ? tgt : old_pc + 32'd4;
    if (live && (sf || !rdy)) m_sc++;
    if (!sd) begin
      if (fd || !take) begin
        m_instr = 0; m_pcp4 = 0; m_valid = 0;
      end else begin
        m_instr = word; m_pcp4 = old_pc + 32'd4; m_valid = 1; m_fc++;
      end
    end
    if (live && rdy && word == HALT_W) m_halt = 1;
    m_run = 1;
    @(posedge clk); #1;
    checks++;
    if (imem_addr !== m_pc || instr_d !== m_instr || pcplus4_d !== m_pcp4 || valid_d !== m_valid ||
        imem_req !== (m_run && !m_halt) || halted !== m_halt) begin
      failures++;
      $display("FAIL %s actual addr=%h instr=%h pcp4=%h v=%b req=%b h=%b required addr=%h instr=%h pcp4=%h v=%b req=%b h=%b",
               name, imem_addr, instr_d, pcplus4_d, valid_d, imem_req, halted,
               m_pc, m_instr, m_pcp4, m_valid, m_run && !m_halt, m_halt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = w(i * 4);
    drv(7'b0, 0, 0, 0);
    tbl[0]  = v(7'b1000000, 0, 0, 32'h00, 0, 0, 0);
    tbl[1]  = v(7'b1000000, 0, 0, 32'h04, w(32'h00), 32'h04, 1);
    tbl[2]  = v(7'b1000000, 0, 0, 32'h08, w(32'h04), 32'h08, 1);
    tbl[3]  = v(7'b0000000, 0, 0, 32'h08, 0, 0, 0);
    tbl[4]  = v(7'b0000000, 0, 0, 32'h08, 0, 0, 0);
    tbl[5]  = v(7'b0000000, 0, 0, 32'h08, 0, 0, 0);
    tbl[6]  = v(7'b1000000, 0, 0, 32'h0C, w(32'h08), 32'h0C, 1);
    tbl[7]  = v(7'b1001100, 32'h40, 0, 32'h40, 0, 0, 0);
    tbl[8]  = v(7'b1001101, 32'h40, 32'h80, 32'h80, 0, 0, 0);
    tbl[9]  = v(7'b1001010, 32'h42, 0, 32'h40, 0, 0, 0);
    tbl[10] = v(7'b1000000, 0, 0, 32'h44, w(32'h40), 32'h44, 1);
    tbl[11] = v(7'b1110100, 32'h20, 0, 32'h44, w(32'h40), 32'h44, 1);
    tbl[12] = v(7'b1110000, 0, 0, 32'h44, w(32'h40), 32'h44, 1);
    tbl[13] = v(7'b1000100, 32'h20, 0, 32'h20, w(32'h44), 32'h48, 1);
    tbl[14] = v(7'b1011000, 0, 0, 32'h24, w(32'h44), 32'h48, 1);
    tbl[15] = v(7'b1100000, 0, 0, 32'h24, 0, 0, 0);
    tbl[16] = v(7'b0000100, 32'h30, 0, 32'h30, 0, 0, 0);
    tbl[17] = v(7'b1000000, 0, 0, 32'h34, w(32'h30), 32'h34, 1);
    // reset state
    #12;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pcp4", pcplus4_d, 32'h0);
    chk("rst_valid", {31'b0, valid_d}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    // directed table
    for (int i = 0; i < 18; i++) begin
      drv(tbl[i].ctl, tbl[i].t1, tbl[i].t1, tbl[i].t2);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr", i), instr_d, tbl[i].instr);
      chk($sformatf("tbl%0d_pcp4", i), pcplus4_d, tbl[i].pcp4);
      chk($sformatf("tbl%0d_valid", i), {31'b0, valid_d}, {31'b0, tbl[i].valid});
      if (i == 0) chk("idle_req_after", {31'b0, imem_req}, 32'h1);
    end
    // halt sequence and asynchronous reset out of HALT
    mem[4] = HALT_W;
    drv(7'b1001010, 0, 32'h10, 0);
    @(posedge clk); #1;
    chk("halt_pre_addr", imem_addr, 32'h10);
    drv(7'b1000000, 0, 0, 0);
    @(posedge clk); #1;
    chk("halt_halted", {31'b0, halted}, 32'h1);
    chk("halt_req", {31'b0, imem_req}, 32'h0);
    chk("halt_addr", imem_addr, 32'h10);
    chk("halt_valid", {31'b0, valid_d}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drv(7'b1000101, 32'h40, 0, 32'h80);
      @(posedge clk); #1;
      chk($sformatf("halt_redir%0d_addr", i), imem_addr, 32'h10);
      chk($sformatf("halt_redir%0d_halted", i), {31'b0, halted}, 32'h1);
    end
    drv(7'b0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_halted", {31'b0, halted}, 32'h0);
    chk("async_rst_req", {31'b0, imem_req}, 32'h0);
    // model-checked phase: perf pattern, wrap, then random traffic
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_W) mem[i] = 32'h1234_5678;
    end
    m_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    step("idle", 7'b1000000, 0, 0, 0);
    foreach (tbl[i]) if (i < 7) step("perf", (i == 2 || i == 4) ? 7'b0000000 : 7'b1000000, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_count", fetch_count, 32'd5);
    chk("stall_count", stall_count, 32'd2);
`endif
    step("wrap_jump", 7'b1001010, 0, 32'hFFFF_FFFF, 0);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step("wrap_inc", 7'b1000000, 0, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic [6:0] c;
      c[6] = $urandom_range(0, 3) != 0;
      c[5] = $urandom_range(0, 5) == 0;
      c[4] = $urandom_range(0, 6) == 0;
      c[3] = $urandom_range(0, 7) == 0;
      c[2] = $urandom_range(0, 5) == 0;
      c[1] = $urandom_range(0, 7) == 0;
      c[0] = $urandom_range(0, 9) == 0;
      step($sformatf("rand%0d", n), c, $urandom, $urandom, $urandom);
    end
`ifdef IF_PERF_CNT_EN
    chk("rand_fetch_count", fetch_count, m_fc);
    chk("rand_stall_count", stall_count, m_sc);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
